// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM states and default
// frame geometry used by the transmitter and receiver.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a down-counter reloaded on start, pulsing bit_end once
// every OVERSAMPLE cycles (bit_pre marks the cycle before).
module uart_bit_timer import uart_pkg::*; #(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic uart_clk,
    input  logic rst,
    input  logic start,
    output logic bit_end,
    output logic bit_pre
);

    localparam int unsigned         CNT_W  = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]    RELOAD = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= RELOAD;
            running <= 1'b1;
        end else if (running) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
        end
    end

    assign bit_end = running && (cnt == '0);
    assign bit_pre = running && (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: fetches words from a normal-mode TX FIFO and sends
// start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_frame import uart_pkg::*; #(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 uart_clk,
    input  logic                 rst,
    input  logic                 tf_empty,
    input  logic [DATA_BITS-1:0] tf_data,
    output logic                 tf_rdreq,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 uart_txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            state;
    parity_e              par_q;
    logic                 stop2_q;
    logic                 stop_more;
    logic                 par_acc;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 bit_end;
    logic                 bit_pre;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .uart_clk (uart_clk),
        .rst      (rst),
        .start    (state == LOAD),
        .bit_end  (bit_end),
        .bit_pre  (bit_pre)
    );

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            stop_more <= 1'b0;
            par_acc   <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            tf_rdreq  <= 1'b0;
            uart_txd  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tf_rdreq <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (!tf_empty) begin
                        tf_rdreq <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shreg    <= tf_data;
                    par_q    <= decode_parity(parity_mode);
                    stop2_q  <= stop2;
                    par_acc  <= 1'b0;
                    bit_idx  <= '0;
                    uart_txd <= 1'b0;
                    state    <= START;
                end
                START: if (bit_end) begin
                    uart_txd <= shreg[0];
                    state    <= DATA;
                end
                // shreg[0] is always the bit currently on the line.
                DATA: if (bit_end) begin
                    par_acc <= par_acc ^ shreg[0];
                    if (bit_idx == LAST_IDX) begin
                        if (par_q == PAR_NONE) begin
                            uart_txd  <= 1'b1;
                            stop_more <= stop2_q;
                            state     <= STOP;
                        end else begin
                            uart_txd <= par_acc ^ shreg[0] ^ (par_q == PAR_ODD);
                            state    <= PARITY;
                        end
                    end else begin
                        shreg    <= shreg >> 1;
                        uart_txd <= shreg[1];
                        bit_idx  <= bit_idx + IDX_W'(1);
                    end
                end
                PARITY: if (bit_end) begin
                    uart_txd  <= 1'b1;
                    stop_more <= stop2_q;
                    state     <= STOP;
                end
                STOP: begin
                    if (bit_pre && !stop_more) tx_done <= 1'b1;
                    if (bit_end) begin
                        if (stop_more) begin
                            stop_more <= 1'b0;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a default 8-bit/x16 instance and a
// 7-bit/x8 instance, each fed by a small FIFO model and decoded off the line.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    typedef struct {
        logic [8:0] word;
        int         has_par;
        logic       par;
        int         nstop;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, rst_b;
    logic [1:0] pm_a, pm_b;
    logic       s2_a, s2_b;
    logic [7:0] tf_data_a = '0;
    logic [6:0] tf_data_b = '0;
    logic       tf_empty_a, tf_empty_b;
    logic       rdreq_a, rdreq_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] fmem_a [0:31];
    logic [6:0] fmem_b [0:31];
    int wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;

    assign tf_empty_a = (wr_a == rd_a);
    assign tf_empty_b = (wr_b == rd_b);

    // Normal-mode FIFO: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (rdreq_a && !tf_empty_a) begin
            tf_data_a <= fmem_a[rd_a % 32];
            rd_a      <= rd_a + 1;
        end
        if (rdreq_b && !tf_empty_b) begin
            tf_data_b <= fmem_b[rd_b % 32];
            rd_b      <= rd_b + 1;
        end
    end

    uart_tx_frame dut_a (
        .uart_clk    (clk),
        .rst         (rst_a),
        .tf_empty    (tf_empty_a),
        .tf_data     (tf_data_a),
        .tf_rdreq    (rdreq_a),
        .parity_mode (pm_a),
        .stop2       (s2_a),
        .uart_txd    (txd_a),
        .busy        (busy_a),
        .tx_done     (done_a)
    );

    uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
        .uart_clk    (clk),
        .rst         (rst_b),
        .tf_empty    (tf_empty_b),
        .tf_data     (tf_data_b),
        .tf_rdreq    (rdreq_b),
        .parity_mode (pm_b),
        .stop2       (s2_b),
        .uart_txd    (txd_b),
        .busy        (busy_b),
        .tx_done     (done_b)
    );

    exp_t exp_a[$], exp_b[$];
    int   start_a[$], start_b[$], flen_a[$], flen_b[$];
    logic [1:0] mon_busy = '0;
    int   abort_cnt = 0;
    int   rq_a = 0, rq_b = 0, td_a = 0, td_b = 0, rd_err = 0;
    int   n_pass = 0, n_chk = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic txd_of(input int w);   return w ? txd_b  : txd_a;   endfunction
    function automatic logic busy_of(input int w);  return w ? busy_b : busy_a;  endfunction
    function automatic logic done_of(input int w);  return w ? done_b : done_a;  endfunction
    function automatic logic rst_of(input int w);   return w ? rst_b  : rst_a;   endfunction

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    task automatic push_word(input int w, input logic [8:0] word);
        exp_t       e;
        logic [1:0] pm;
        logic       xr;
        @(negedge clk);
        pm        = w ? pm_b : pm_a;
        xr        = w ? ^word[6:0] : ^word[7:0];
        e.word    = w ? {2'b00, word[6:0]} : {1'b0, word[7:0]};
        e.nstop   = (w ? s2_b : s2_a) ? 2 : 1;
        e.has_par = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
        e.par     = (pm == 2'b10) ? ~xr : xr;
        if (w == 0) begin
            exp_a.push_back(e);
            fmem_a[wr_a % 32] = word[7:0];
            wr_a++;
        end else begin
            exp_b.push_back(e);
            fmem_b[wr_b % 32] = word[6:0];
            wr_b++;
        end
    endtask

    // Decodes frames off the line, checking every cycle of every bit.
    task automatic monitor(input int w);
        exp_t       e;
        int         os, db, nbits, glitch, stop_bad, done_at, nexp;
        logic [8:0] got;
        logic       prev, cur, first, v, pbit, aborted;
        os   = w ? 8 : 16;
        db   = w ? 7 : 8;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_of(w)) begin
                prev = 1'b1;
                continue;
            end
            cur = txd_of(w);
            if (prev && !cur) begin
                mon_busy[w] = 1'b1;
                if (w == 0) start_a.push_back(cyc); else start_b.push_back(cyc);
                nexp = (w == 0) ? exp_a.size() : exp_b.size();
                if (nexp == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                    e.word = '0; e.has_par = 0; e.par = 1'b0; e.nstop = 1;
                end else begin
                    e = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
                end
                nbits = 1 + db + e.has_par + e.nstop;
                glitch = 0; stop_bad = 0; done_at = 0; aborted = 1'b0;
                got = '0; pbit = 1'b0; first = 1'b0;
                for (int b = 0; b < nbits; b++) begin
                    for (int k = 0; k < os; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst_of(w)) begin
                            aborted = 1'b1;
                            break;
                        end
                        v = txd_of(w);
                        if (k == 0) first = v;
                        else if (v != first) glitch++;
                        if (done_of(w)) begin
                            if (done_at == 0) done_at = b * os + k + 1;
                            else glitch++;
                        end
                        if (!busy_of(w)) glitch++;
                    end
                    if (aborted) break;
                    if (b >= 1 && b <= db) got[b-1] = first;
                    else if (b == db + 1 && e.has_par != 0) pbit = first;
                    else if (b > db && !first) stop_bad++;
                end
                if (aborted) begin
                    abort_cnt++;
                    mon_busy[w] = 1'b0;
                    prev = 1'b1;
                    continue;
                end
                check_eq(w ? "b_word" : "a_word", got, e.word);
                if (e.has_par != 0) check_eq(w ? "b_parity" : "a_parity", pbit, e.par);
                check_eq(w ? "b_stop_low" : "a_stop_low", stop_bad, 0);
                check_eq(w ? "b_bit_hold" : "a_bit_hold", glitch, 0);
                check_eq(w ? "b_done_pos" : "a_done_pos", done_at, nbits * os);
                if (w == 0) flen_a.push_back(done_at); else flen_b.push_back(done_at);
                @(negedge clk);
                check_eq(w ? "b_after_frame" : "a_after_frame",
                         {busy_of(w), txd_of(w), done_of(w)}, 3'b010);
                prev = txd_of(w);
                mon_busy[w] = 1'b0;
                continue;
            end
            prev = cur;
        end
    endtask

    task automatic rd_watch();
        logic pa, pb;
        pa = 1'b0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rdreq_a) begin
                rq_a++;
                if (pa || tf_empty_a) rd_err++;
            end
            if (rdreq_b) begin
                rq_b++;
                if (pb || tf_empty_b) rd_err++;
            end
            if (done_a) td_a++;
            if (done_b) td_b++;
            pa = rdreq_a;
            pb = rdreq_b;
        end
    endtask

    task automatic wait_done(input int w, input int limit, input string tag);
        logic ok;
        int   nexp;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            nexp = (w == 0) ? exp_a.size() : exp_b.size();
            if (nexp == 0 && !mon_busy[w] && !busy_of(w) &&
                (w ? tf_empty_b : tf_empty_a)) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, ok, 1'b1);
    endtask

    task automatic wait_start(input int w, input int limit, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!txd_of(w)) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, seen, 1'b1);
    endtask

    initial begin
        int base_rq, base_ab, n0, viol;
        rst_a = 1'b1; rst_b = 1'b1;
        pm_a = 2'b00; pm_b = 2'b10;
        s2_a = 1'b0;  s2_b = 1'b0;
        fork
            monitor(0);
            monitor(1);
            rd_watch();
        join_none

        repeat (3) @(negedge clk);
        check_eq("rst_a_outputs", {txd_a, rdreq_a, busy_a, done_a}, 4'b1000);
        check_eq("rst_b_outputs", {txd_b, rdreq_b, busy_b, done_b}, 4'b1000);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);

        // 8N1, 0x55
        base_rq = rq_a;
        push_word(0, 9'h055);
        wait_done(0, 400, "t1_timeout");
        check_eq("t1_len", last_of(flen_a), 160);
        check_eq("t1_rdreq", rq_a - base_rq, 1);
        check_eq("t1_tx_done", td_a, 1);

        // 8E1 then 8O1, 0x07
        pm_a = 2'b01;
        push_word(0, 9'h007);
        wait_done(0, 400, "t2e_timeout");
        check_eq("t2e_len", last_of(flen_a), 176);
        pm_a = 2'b10;
        push_word(0, 9'h007);
        wait_done(0, 400, "t2o_timeout");
        check_eq("t2o_len", last_of(flen_a), 176);

        // 8N2, three preloaded words
        pm_a = 2'b00; s2_a = 1'b1;
        base_rq = rq_a;
        n0 = start_a.size();
        push_word(0, 9'h0A3);
        push_word(0, 9'h000);
        push_word(0, 9'h0FF);
        wait_done(0, 700, "t3_timeout");
        check_eq("t3_rdreq", rq_a - base_rq, 3);
        check_eq("t3_frames", start_a.size() - n0, 3);
        if (start_a.size() >= n0 + 3) begin
            check_eq("t3_gap1", start_a[n0+1] - start_a[n0], 179);
            check_eq("t3_gap2", start_a[n0+2] - start_a[n0+1], 179);
        end
        check_eq("t3_len", last_of(flen_a), 176);

        // Empty FIFO: line stays idle
        s2_a = 1'b0;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rdreq_a || !txd_a || busy_a) viol++;
        end
        check_eq("t4_idle_viol", viol, 0);

        // Reset during DATA bit 3 of 0x3C, then 0x81
        base_rq = rq_a;
        base_ab = abort_cnt;
        push_word(0, 9'h03C);
        wait_start(0, 50, "t5_start_timeout");
        repeat (16 * 4 + 8) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check_eq("t5_rst_outputs", {txd_a, rdreq_a, busy_a, done_a}, 4'b1000);
        push_word(0, 9'h081);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        wait_done(0, 400, "t5_timeout");
        check_eq("t5_aborted", abort_cnt - base_ab, 1);
        check_eq("t5_rdreq", rq_a - base_rq, 2);
        check_eq("t5_len", last_of(flen_a), 160);

        // 7 bits, x8, odd parity switched to none mid-frame
        pm_b = 2'b10;
        push_word(1, 9'h05A);
        wait_start(1, 50, "t6_start_timeout");
        repeat (20) @(negedge clk);
        pm_b = 2'b00;
        push_word(1, 9'h033);
        wait_done(1, 300, "t6_timeout");
        check_eq("t6_frames", flen_b.size(), 2);
        if (flen_b.size() >= 2) begin
            check_eq("t6_len_odd", flen_b[0], 80);
            check_eq("t6_len_none", flen_b[1], 72);
        end
        check_eq("t6_tx_done", td_b, 2);

        repeat (5) @(negedge clk);
        check_eq("rdreq_rules", rd_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
